axi_adapter_arbiter: RTL and testbench
======================================

# axi_adapter_arbiter

Round-robin arbiter that shares one `axi_adapter` instance between `NUM_PORTS` cache-side requesters (e.g. icache refill, dcache writeback, PTW). It serialises requests so at most one transaction is outstanding in the adapter, and routes `gnt`/`valid`/`rdata` back to the owning requester. It owns the adapter's `state_lock_cmd_i`: the lock is asserted only after the adapter has drained to IDLE. It sits between the cache subsystem and `axi_adapter`.

## Interface
- `NUM_PORTS`, 3: number of requesters (2..8).
- `DATA_WIDTH`, 256: must match the adapter's `DATA_WIDTH`; `NW = DATA_WIDTH/riscv::XLEN`.
- `AXI_ID_WIDTH`, 10: ID width.
- `TIMEOUT_CYCLES`, 1024: response-wait limit; must be ≥2.

Ports:
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset. One clock; reset is asynchronous and active-low.
- `req_i / we_i`  in  [NUM_PORTS]  per-port request / write.
- `type_i`  in  [NUM_PORTS] x ariane_axi::ad_req_t  per-port single or cacheline request.
- `addr_i`  in  [NUM_PORTS][XLEN]  per-port address.
- `wdata_i`  in  [NUM_PORTS][NW][XLEN]  per-port write data.
- `be_i`  in  [NUM_PORTS][NW][XLEN/8]  per-port byte enables.
- `size_i`  in  [NUM_PORTS][2]  per-port size.
- `id_i`  in  [NUM_PORTS][AXI_ID_WIDTH]  per-port ID.
- `gnt_o / valid_o`  out  [NUM_PORTS]  per-port grant / completion.
- `rdata_o`  out  [NW][XLEN]  shared read data; qualified by `valid_o`.
- `id_o`  out  AXI_ID_WIDTH  shared response ID.
- `ad_*_o`  out  adapter request fields (req, type, addr, we, wdata, be, size, id).
- `ad_gnt_i, ad_valid_i, ad_rdata_i, ad_id_i`  in  adapter responses.
- `ad_lock_o`  out  1  drives the adapter's `state_lock_cmd_i`.
- `lock_req_i`  in  1  system request to freeze the adapter.
- `lock_ack_o`  out  1  high while locked.
- `timeout_o`  out  1  sticky: a response exceeded `TIMEOUT_CYCLES`.

## Operation
FSM `state_q`: ARB, REQ, RESP, LOCKED. Reset state is ARB.

- **ARB**
  - If `lock_req_i` is high: go to LOCKED. Lock has priority over pending requests.
  - Else if any `req_i` is set: pick the first set bit at or after `rr_ptr_q`, scanning upward and wrapping. Register it in `owner_q` and go to REQ.
- **REQ**
  - `ad_req_o = req_i[owner_q]`. All `ad_*` fields are muxed combinationally from `owner_q`.
  - `gnt_o[owner_q] = ad_gnt_i`.
  - On `ad_gnt_i`: go to RESP and set `rr_ptr_d = owner_q+1 mod NUM_PORTS`.
  - If the owner drops `req_i` before the grant: return to ARB with no pointer update. This is illegal per protocol, but it must not hang.
- **RESP**
  - `ad_req_o = 0`. Fields stay muxed from `owner_q`, because the adapter re-reads `type_i` in burst states.
  - `valid_o[owner_q] = ad_valid_i`; `id_o = ad_id_i`; `rdata_o = ad_rdata_i`.
  - On `ad_valid_i`: go to ARB.
  - `tmo_cnt_q` increments each cycle in RESP. At `TIMEOUT_CYCLES-1` set `timeout_o`; the transaction is not aborted.
- **LOCKED**
  - `ad_lock_o = 1`, `lock_ack_o = 1`; no grants are issued.
  - When `lock_req_i` deasserts: go to ARB.
- Write completion (B response) and read completion (COMPLETE_READ) both appear as a single `ad_valid_i` pulse; they are handled identically.
- Widths: `rr_ptr_q` and `owner_q` are `$clog2(NUM_PORTS)` bits; `tmo_cnt_q` is `$clog2(TIMEOUT_CYCLES)` bits and saturates.

## Timing
- Reset values: all outputs 0; `rr_ptr_q = 0`, `owner_q = 0`, `tmo_cnt_q = 0`, `timeout_o = 0`.
- Arbitration latency: `req_i` in cycle N → `ad_req_o` in N+1. Minimum request→`gnt_o` is 1 cycle.
- Grant and valid paths are combinational (adapter → requester); they add no cycles.
- Back-to-back: after `valid_o` in cycle M, the next `ad_req_o` is no earlier than M+2 (one cycle in ARB).
- `lock_req_i` raised during REQ/RESP: the transaction completes, then the ARB→LOCKED cycle follows, so `ad_lock_o` rises 2 cycles after `ad_valid_i`. `ad_lock_o` is never asserted outside LOCKED.
- Unlock: `lock_req_i` falls in cycle K → `lock_ack_o` is 0 in K+1; arbitration resumes in K+1.
- Async reset mid-transaction: immediate return to ARB with outputs cleared. The adapter shares `rst_ni`, so both restart together.
- `timeout_o` clears only on reset.

## Structure
- `ariane_axi` package (existing) supplies `ad_req_t`.
- The arbiter state enum and `arb_state_t` belong in `ariane_axi` next to `ad_req_t`.
- One sub-module, `rr_pick` (`NUM_PORTS`): combinational first-set-bit search from a pointer, with wrap. Inputs: req vector and pointer; outputs: index and valid.

## Test plan
- Single port 0 read, adapter grants in 3 cycles, valid 5 cycles later → `gnt_o = 3'b001` for 1 cycle, `valid_o = 3'b001`, `rdata_o` matches, `rr_ptr = 1`.
- All three ports request continuously, zero-wait adapter → grant order 0,1,2,0,1; at most one `ad_req` outstanding.
- Port 2 cacheline write with `ad_gnt_i` delayed 4 cycles → `ad_wdata_o`/`ad_type_o` are stable from port 2 throughout REQ and RESP.
- `lock_req_i` raised mid-RESP → `ad_lock_o` stays 0 until 2 cycles after `ad_valid_i`, then 1 with `lock_ack_o = 1`; pending `req_i` is not granted; release → port granted in the next cycle.
- Adapter never returns valid → `timeout_o = 1` after 1024 RESP cycles; FSM remains in RESP.
- `rst_ni` pulsed low during REQ → all outputs 0 asynchronously; after release, ARB with `rr_ptr = 0`.

Source files
------------

// File: rtl/axi_adapter_arbiter_pkg.sv
// Shared types for the adapter arbiter slice: request kind,
// arbiter FSM state and the XLEN the data paths are built from.
package axi_adapter_arbiter_pkg;

    localparam int XLEN = 64;

    typedef enum logic {
        SINGLE_REQ,
        CACHE_LINE_REQ
    } ad_req_t;

    typedef enum logic [1:0] {
        ARB,
        REQ,
        RESP,
        LOCKED
    } arb_state_t;

endpackage

// File: rtl/axi_adapter_arbiter_if.sv
// Cache-side bundle of the adapter arbiter: per-port requests
// going in, per-port grant/valid and shared response coming back.
interface axi_adapter_arbiter_if
    import axi_adapter_arbiter_pkg::*;
#(
    parameter int NUM_PORTS    = 3,
    parameter int DATA_WIDTH   = 256,
    parameter int AXI_ID_WIDTH = 10
) ();

    localparam int NW = DATA_WIDTH / XLEN;

    logic    [NUM_PORTS-1:0]                   req_i;
    logic    [NUM_PORTS-1:0]                   we_i;
    ad_req_t                                   type_i [NUM_PORTS];
    logic    [NUM_PORTS-1:0][XLEN-1:0]         addr_i;
    logic    [NUM_PORTS-1:0][NW-1:0][XLEN-1:0] wdata_i;
    logic    [NUM_PORTS-1:0][NW-1:0][XLEN/8-1:0] be_i;
    logic    [NUM_PORTS-1:0][1:0]              size_i;
    logic    [NUM_PORTS-1:0][AXI_ID_WIDTH-1:0] id_i;

    logic    [NUM_PORTS-1:0]                   gnt_o;
    logic    [NUM_PORTS-1:0]                   valid_o;
    logic    [NW-1:0][XLEN-1:0]                rdata_o;
    logic    [AXI_ID_WIDTH-1:0]                id_o;

    modport master (
        output req_i, we_i, type_i, addr_i,
        output wdata_i, be_i, size_i, id_i,
        input  gnt_o, valid_o, rdata_o, id_o
    );

    modport slave (
        input  req_i, we_i, type_i, addr_i,
        input  wdata_i, be_i, size_i, id_i,
        output gnt_o, valid_o, rdata_o, id_o
    );

endinterface

// File: rtl/axi_adapter_arbiter_rr_pick.sv
// Round-robin pick: first set request at or after ptr_i,
// scanning upward and wrapping around NUM_PORTS.
module axi_adapter_arbiter_rr_pick #(
    parameter int NUM_PORTS = 3,
    localparam int PW = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic [PW-1:0]        ptr_i,
    output logic [PW-1:0]        idx_o,
    output logic                 valid_o
);

    int j;

    // Walk offsets high to low so the nearest hit wins.
    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        j       = 0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            j = int'(ptr_i) + i;
            if (j >= NUM_PORTS) j = j - NUM_PORTS;
            if (req_i[PW'(j)]) begin
                idx_o   = PW'(j);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi_adapter_arbiter.sv
// Round-robin arbiter sharing one axi_adapter between cache
// requesters; one transaction in flight, lock only when drained.
module axi_adapter_arbiter
    import axi_adapter_arbiter_pkg::*;
#(
    parameter int NUM_PORTS      = 3,
    parameter int DATA_WIDTH     = 256,
    parameter int AXI_ID_WIDTH   = 10,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int NW = DATA_WIDTH / XLEN,
    localparam int PW = $clog2(NUM_PORTS)
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    axi_adapter_arbiter_if.slave          cache,
    output logic                          ad_req_o,
    output ad_req_t                       ad_type_o,
    output logic [XLEN-1:0]               ad_addr_o,
    output logic                          ad_we_o,
    output logic [NW-1:0][XLEN-1:0]       ad_wdata_o,
    output logic [NW-1:0][XLEN/8-1:0]     ad_be_o,
    output logic [1:0]                    ad_size_o,
    output logic [AXI_ID_WIDTH-1:0]       ad_id_o,
    input  logic                          ad_gnt_i,
    input  logic                          ad_valid_i,
    input  logic [NW-1:0][XLEN-1:0]       ad_rdata_i,
    input  logic [AXI_ID_WIDTH-1:0]       ad_id_i,
    output logic                          ad_lock_o,
    input  logic                          lock_req_i,
    output logic                          lock_ack_o,
    output logic                          timeout_o
);

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CYCLES - 1);

    arb_state_t        state_q, state_d;
    logic [PW-1:0]     owner_q, owner_d;
    logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [TMO_W-1:0]  tmo_cnt_q;
    logic              timeout_q;
    logic [PW-1:0]     pick_idx;
    logic              pick_valid;
    logic              own;

    logic [NUM_PORTS-1:0]     gnt;
    logic [NUM_PORTS-1:0]     valid;
    logic [NW-1:0][XLEN-1:0]  rdata;
    logic [AXI_ID_WIDTH-1:0]  id;

    axi_adapter_arbiter_rr_pick #(
        .NUM_PORTS (NUM_PORTS)
    ) u_pick (
        .req_i   (cache.req_i),
        .ptr_i   (rr_ptr_q),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ARB;
            owner_q   <= '0;
            rr_ptr_q  <= '0;
            tmo_cnt_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            if (state_q != RESP)
                tmo_cnt_q <= '0;
            else if (tmo_cnt_q != TMO_MAX)
                tmo_cnt_q <= tmo_cnt_q + 1'b1;
            // Sticky flag only; the transaction keeps waiting.
            if (state_q == RESP && tmo_cnt_q == TMO_MAX && !ad_valid_i)
                timeout_q <= 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        unique case (state_q)
            ARB: begin
                if (lock_req_i) begin
                    state_d = LOCKED;
                end else if (pick_valid) begin
                    owner_d = pick_idx;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (!cache.req_i[owner_q]) begin
                    state_d = ARB;
                end else if (ad_gnt_i) begin
                    state_d  = RESP;
                    rr_ptr_d = (owner_q == PW'(NUM_PORTS - 1))
                             ? '0 : owner_q + 1'b1;
                end
            end
            RESP: begin
                if (ad_valid_i) state_d = ARB;
            end
            LOCKED: begin
                if (!lock_req_i) state_d = ARB;
            end
            default: state_d = ARB;
        endcase
    end

    assign own = (state_q == REQ) || (state_q == RESP);

    // Fields stay on the owner through RESP for burst re-reads.
    always_comb begin
        ad_req_o   = 1'b0;
        ad_type_o  = SINGLE_REQ;
        ad_addr_o  = '0;
        ad_we_o    = 1'b0;
        ad_wdata_o = '0;
        ad_be_o    = '0;
        ad_size_o  = '0;
        ad_id_o    = '0;
        ad_lock_o  = 1'b0;
        lock_ack_o = 1'b0;
        gnt        = '0;
        valid      = '0;
        rdata      = '0;
        id         = '0;
        if (own) begin
            ad_type_o  = cache.type_i[owner_q];
            ad_addr_o  = cache.addr_i[owner_q];
            ad_we_o    = cache.we_i[owner_q];
            ad_wdata_o = cache.wdata_i[owner_q];
            ad_be_o    = cache.be_i[owner_q];
            ad_size_o  = cache.size_i[owner_q];
            ad_id_o    = cache.id_i[owner_q];
        end
        unique case (state_q)
            REQ: begin
                ad_req_o     = cache.req_i[owner_q];
                gnt[owner_q] = ad_gnt_i;
            end
            RESP: begin
                valid[owner_q] = ad_valid_i;
                rdata          = ad_rdata_i;
                id             = ad_id_i;
            end
            LOCKED: begin
                ad_lock_o  = 1'b1;
                lock_ack_o = 1'b1;
            end
            default: ;
        endcase
    end

    assign cache.gnt_o   = gnt;
    assign cache.valid_o = valid;
    assign cache.rdata_o = rdata;
    assign cache.id_o    = id;
    assign timeout_o     = timeout_q;

endmodule

// File: tb/tb_axi_adapter_arbiter.sv
// Directed bench for axi_adapter_arbiter with a hand-driven
// adapter model and immediate-assertion checks.
module tb_axi_adapter_arbiter;
    import axi_adapter_arbiter_pkg::*;

    localparam int NP = 3;
    localparam int NW = 4;
    localparam int IW = 10;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;

    logic                      ad_req_o;
    ad_req_t                   ad_type_o;
    logic [XLEN-1:0]           ad_addr_o;
    logic                      ad_we_o;
    logic [NW-1:0][XLEN-1:0]   ad_wdata_o;
    logic [NW-1:0][XLEN/8-1:0] ad_be_o;
    logic [1:0]                ad_size_o;
    logic [IW-1:0]             ad_id_o;
    logic                      ad_gnt_i = 1'b0;
    logic                      ad_valid_i = 1'b0;
    logic [NW-1:0][XLEN-1:0]   ad_rdata_i = '0;
    logic [IW-1:0]             ad_id_i = '0;
    logic                      ad_lock_o;
    logic                      lock_req_i = 1'b0;
    logic                      lock_ack_o;
    logic                      timeout_o;

    int n_cmp = 0;
    int n_bad = 0;

    logic [255:0] w2;
    logic [255:0] w0;
    logic [255:0] rd;

    axi_adapter_arbiter_if #(
        .NUM_PORTS    (NP),
        .DATA_WIDTH   (256),
        .AXI_ID_WIDTH (IW)
    ) cif ();

    axi_adapter_arbiter dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .cache      (cif),
        .ad_req_o   (ad_req_o),
        .ad_type_o  (ad_type_o),
        .ad_addr_o  (ad_addr_o),
        .ad_we_o    (ad_we_o),
        .ad_wdata_o (ad_wdata_o),
        .ad_be_o    (ad_be_o),
        .ad_size_o  (ad_size_o),
        .ad_id_o    (ad_id_o),
        .ad_gnt_i   (ad_gnt_i),
        .ad_valid_i (ad_valid_i),
        .ad_rdata_i (ad_rdata_i),
        .ad_id_i    (ad_id_i),
        .ad_lock_o  (ad_lock_o),
        .lock_req_i (lock_req_i),
        .lock_ack_o (lock_ack_o),
        .timeout_o  (timeout_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [255:0] obs,
                       input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        cif.req_i   = '0;
        cif.we_i    = '0;
        cif.addr_i  = '0;
        cif.wdata_i = '0;
        cif.be_i    = '0;
        cif.size_i  = '0;
        cif.id_i    = '0;
        for (int k = 0; k < NP; k++) cif.type_i[k] = SINGLE_REQ;

        // Reset values
        #1;
        chk("rst_ad_req", ad_req_o, 0);
        chk("rst_gnt", cif.gnt_o, 0);
        chk("rst_valid", cif.valid_o, 0);
        chk("rst_lock", ad_lock_o, 0);
        chk("rst_ack", lock_ack_o, 0);
        chk("rst_tmo", timeout_o, 0);
        chk("rst_rdata", cif.rdata_o, 0);
        chk("rst_ptr", dut.rr_ptr_q, 0);
        @(negedge clk);
        rst_ni = 1'b1;

        // Port 0 read: grant on 3rd REQ cycle, valid 5 later
        cyc();
        cif.req_i     = 3'b001;
        cif.addr_i[0] = 64'h1000;
        cif.id_i[0]   = 10'd5;
        #1;
        chk("t1_arb_req", ad_req_o, 0);
        cyc();
        chk("t1_req", ad_req_o, 1);
        chk("t1_addr", ad_addr_o, 64'h1000);
        chk("t1_nognt", cif.gnt_o, 0);
        cyc();
        chk("t1_nognt2", cif.gnt_o, 0);
        cyc();
        ad_gnt_i = 1'b1;
        #1;
        chk("t1_gnt", cif.gnt_o, 3'b001);
        cyc();
        ad_gnt_i  = 1'b0;
        cif.req_i = '0;
        #1;
        chk("t1_gnt_off", cif.gnt_o, 0);
        chk("t1_resp_req", ad_req_o, 0);
        chk("t1_ptr", dut.rr_ptr_q, 1);
        chk("t1_addr_hold", ad_addr_o, 64'h1000);
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("t1_novalid", cif.valid_o, 0);
        end
        cyc();
        rd = {4{64'hDEAD_BEEF_0000_0001}};
        ad_rdata_i = rd;
        ad_id_i    = 10'd5;
        ad_valid_i = 1'b1;
        #1;
        chk("t1_valid", cif.valid_o, 3'b001);
        chk("t1_rdata", cif.rdata_o, rd);
        chk("t1_id", cif.id_o, 5);
        cyc();
        ad_valid_i = 1'b0;
        #1;
        chk("t1_valid_off", cif.valid_o, 0);
        chk("t1_rdata_off", cif.rdata_o, 0);
        chk("t1_st", dut.state_q, ARB);

        // Three ports, zero-wait adapter: order 0,1,2,0,1
        rst_ni = 1'b0;
        #1;
        rst_ni = 1'b1;
        chk("t2_ptr0", dut.rr_ptr_q, 0);
        for (int k = 0; k < NP; k++) cif.id_i[k] = IW'(k + 1);
        cif.req_i = 3'b111;
        #1;
        for (int k = 0; k < 5; k++) begin
            chk("t2_arb_req", ad_req_o, 0);
            cyc();
            ad_gnt_i = 1'b1;
            #1;
            chk("t2_gnt", cif.gnt_o, 3'b001 << (k % 3));
            chk("t2_id", ad_id_o, (k % 3) + 1);
            cyc();
            ad_gnt_i   = 1'b0;
            ad_valid_i = 1'b1;
            #1;
            chk("t2_valid", cif.valid_o, 3'b001 << (k % 3));
            chk("t2_one_out", ad_req_o, 0);
            cyc();
            ad_valid_i = 1'b0;
            #1;
        end
        cif.req_i = '0;

        // Port 2 cacheline write, grant after 4 REQ cycles
        w2 = {4{64'hA5A5_0000_2222_0002}};
        w0 = {4{64'h5A5A_0000_1111_0000}};
        cif.wdata_i[2] = w2;
        cif.wdata_i[0] = w0;
        cif.we_i       = 3'b100;
        cif.type_i[2]  = CACHE_LINE_REQ;
        cif.req_i      = 3'b100;
        #1;
        chk("t3_arb_req", ad_req_o, 0);
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk("t3_req", ad_req_o, 1);
            chk("t3_wdata_req", ad_wdata_o, w2);
            chk("t3_type_req", ad_type_o, CACHE_LINE_REQ);
            chk("t3_we", ad_we_o, 1);
        end
        cyc();
        ad_gnt_i = 1'b1;
        #1;
        chk("t3_gnt", cif.gnt_o, 3'b100);
        cyc();
        ad_gnt_i  = 1'b0;
        cif.req_i = '0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("t3_wdata_resp", ad_wdata_o, w2);
            chk("t3_type_resp", ad_type_o, CACHE_LINE_REQ);
            cyc();
        end
        ad_valid_i = 1'b1;
        #1;
        chk("t3_valid", cif.valid_o, 3'b100);
        chk("t3_type_last", ad_type_o, CACHE_LINE_REQ);
        cyc();
        ad_valid_i = 1'b0;
        cif.we_i   = '0;
        #1;

        // Lock raised mid-RESP, pending port 1 held off
        cif.req_i = 3'b001;
        #1;
        cyc();
        ad_gnt_i = 1'b1;
        #1;
        chk("t4_gnt", cif.gnt_o, 3'b001);
        cyc();
        ad_gnt_i   = 1'b0;
        cif.req_i  = 3'b010;
        lock_req_i = 1'b1;
        #1;
        chk("t4_st_resp", dut.state_q, RESP);
        chk("t4_lock_r0", ad_lock_o, 0);
        cyc();
        chk("t4_lock_r1", ad_lock_o, 0);
        cyc();
        ad_valid_i = 1'b1;
        #1;
        chk("t4_valid", cif.valid_o, 3'b001);
        chk("t4_lock_v", ad_lock_o, 0);
        cyc();
        ad_valid_i = 1'b0;
        #1;
        chk("t4_lock_arb", ad_lock_o, 0);
        chk("t4_st_arb", dut.state_q, ARB);
        cyc();
        chk("t4_lock_on", ad_lock_o, 1);
        chk("t4_ack_on", lock_ack_o, 1);
        chk("t4_no_req", ad_req_o, 0);
        chk("t4_no_gnt", cif.gnt_o, 0);
        cyc();
        lock_req_i = 1'b0;
        #1;
        chk("t4_ack_k", lock_ack_o, 1);
        cyc();
        chk("t4_ack_off", lock_ack_o, 0);
        chk("t4_lock_off", ad_lock_o, 0);
        chk("t4_st_unlk", dut.state_q, ARB);
        cyc();
        ad_gnt_i = 1'b1;
        #1;
        chk("t4_req1", ad_req_o, 1);
        chk("t4_gnt1", cif.gnt_o, 3'b010);
        cyc();
        ad_gnt_i   = 1'b0;
        cif.req_i  = '0;
        ad_valid_i = 1'b1;
        #1;
        chk("t4_valid1", cif.valid_o, 3'b010);
        cyc();
        ad_valid_i = 1'b0;
        #1;

        // Adapter never answers: sticky timeout after 1024 cycles
        cif.req_i = 3'b001;
        #1;
        cyc();
        ad_gnt_i = 1'b1;
        #1;
        chk("t5_gnt", cif.gnt_o, 3'b001);
        cyc();
        ad_gnt_i  = 1'b0;
        cif.req_i = '0;
        #1;
        chk("t5_tmo_0", timeout_o, 0);
        repeat (1023) cyc();
        chk("t5_tmo_1023", timeout_o, 0);
        chk("t5_st_1023", dut.state_q, RESP);
        cyc();
        chk("t5_tmo_1024", timeout_o, 1);
        chk("t5_st_1024", dut.state_q, RESP);
        cyc();
        ad_valid_i = 1'b1;
        #1;
        chk("t5_valid", cif.valid_o, 3'b001);
        cyc();
        ad_valid_i = 1'b0;
        #1;
        chk("t5_sticky", timeout_o, 1);
        chk("t5_st_arb", dut.state_q, ARB);

        // Async reset while in REQ
        cif.req_i     = 3'b010;
        cif.addr_i[1] = 64'h2040;
        #1;
        cyc();
        ad_gnt_i = 1'b1;
        #1;
        chk("t6_req", ad_req_o, 1);
        chk("t6_gnt", cif.gnt_o, 3'b010);
        rst_ni = 1'b0;
        #1;
        chk("t6_req_clr", ad_req_o, 0);
        chk("t6_gnt_clr", cif.gnt_o, 0);
        chk("t6_addr_clr", ad_addr_o, 0);
        chk("t6_tmo_clr", timeout_o, 0);
        chk("t6_st", dut.state_q, ARB);
        chk("t6_ptr", dut.rr_ptr_q, 0);
        ad_gnt_i  = 1'b0;
        cif.req_i = '0;
        rst_ni    = 1'b1;
        cyc();
        chk("t6_st_post", dut.state_q, ARB);
        chk("t6_ptr_post", dut.rr_ptr_q, 0);
        chk("t6_req_post", ad_req_o, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
